// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding, receiver states, default word width.
package i2s_pkg;

  // Default bits per channel word, shared by the receiver and the transmitter.
  localparam int DEFAULT_DATA_WIDTH = 16;

  // LRCK level encoding for the two channels.
  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  // Receiver framing state.
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_e;

  // True when an LRCK change at a bit-clock rise closes a right word and opens a left one.
  function automatic logic is_right_to_left(input logic lr_prev, input logic lr_now);
    return (lr_prev == LR_RIGHT) && (lr_now == LR_LEFT);
  endfunction

endpackage

// File: rtl/i2s_rx_if.sv
// Output side of the I2S receiver: stereo sample with valid/ready and status pulses.
interface i2s_rx_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [2*DATA_WIDTH-1:0] sample;
  logic                    valid;
  logic                    ready;
  logic                    overrun;
  logic                    len_err;

  modport master (
    output sample,
    output valid,
    output overrun,
    output len_err,
    input  ready
  );

  modport slave (
    input  sample,
    input  valid,
    input  overrun,
    input  len_err,
    output ready
  );

endinterface

// File: rtl/i2s_sync_edge.sv
// Two-flop synchroniser for one pin, with optional rising-edge detect on the
// synchronised level. All pin-to-clkin crossing goes through this block.
module i2s_sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the pin level one stage deeper each clock.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

  generate
    if (EDGE_EN) begin : g_edge
      logic dly_q;
      logic dly_d;

      // Previous synchronised level, for edge detection.
      always_comb begin
        dly_d = sync_q[1];
      end

      // Delay flop behind the synchroniser.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dly_q <= 1'b0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign rise = sync_q[1] & ~dly_q;
    end else begin : g_no_edge
      assign rise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: oversamples SCK/LRCK/SD in the clkin domain, assembles
// MSB-first channel words and emits {left,right} frames on a valid/ready port.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic      clkin,
  input  logic      rst,
  input  logic      sck,
  input  logic      lrck,
  input  logic      sd,
  i2s_rx_if.master  out_if
);

  // Reset: asserts with rst, releases two clkin edges later.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int;

  // Walk zeros into the reset synchroniser once rst drops.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b0};
  end

  // Reset synchroniser: async set, sync release.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int = rst_sync_q[1];

  // Pin synchronisers; only SCK needs an edge.
  logic sck_lvl_s;
  logic sck_rise_s;
  logic lr_now_s;
  logic lr_rise_s;
  logic sd_s;
  logic sd_rise_s;
  logic unused_s;

  i2s_sync_edge #(.EDGE_EN(1'b1)) u_sck_sync (
    .clk(clkin), .rst(rst_int), .d(sck),  .q(sck_lvl_s), .rise(sck_rise_s)
  );
  i2s_sync_edge #(.EDGE_EN(1'b0)) u_lr_sync (
    .clk(clkin), .rst(rst_int), .d(lrck), .q(lr_now_s),  .rise(lr_rise_s)
  );
  i2s_sync_edge #(.EDGE_EN(1'b0)) u_sd_sync (
    .clk(clkin), .rst(rst_int), .d(sd),   .q(sd_s),      .rise(sd_rise_s)
  );

  assign unused_s = sck_lvl_s | lr_rise_s | sd_rise_s;

  // Receiver state.
  rx_state_e               state_q,   state_d;
  logic                    lr_prev_q, lr_prev_d;
  logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
  logic [CNT_WIDTH-1:0]    cnt_q,     cnt_d;
  logic [DATA_WIDTH-1:0]   left_q,    left_d;
  logic [2*DATA_WIDTH-1:0] sample_q,  sample_d;
  logic                    valid_q,   valid_d;
  logic                    overrun_q, overrun_d;
  logic                    len_err_q, len_err_d;

  logic [DATA_WIDTH-1:0]   word_s;
  logic [CNT_WIDTH-1:0]    cnt_inc_s;
  logic                    len_bad_s;

  // Current word with this rise's SD bit placed left-aligned; bits past DATA_WIDTH are dropped.
  always_comb begin
    word_s = shift_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (int'(cnt_q) == DATA_WIDTH - 1 - i) begin
        word_s[i] = sd_s;
      end else begin
        word_s[i] = shift_q[i];
      end
    end
    if (&cnt_q) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_WIDTH'(1'b1);
    end
    len_bad_s = (int'(cnt_inc_s) != DATA_WIDTH);
  end

  // Framing FSM, word assembly and output handshake.
  always_comb begin
    state_d   = state_q;
    lr_prev_d = lr_prev_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    sample_d  = sample_q;
    overrun_d = 1'b0;
    len_err_d = 1'b0;

    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    if (sck_rise_s) begin
      lr_prev_d = lr_now_s;
      if (lr_now_s != lr_prev_q) begin
        // This bit is the LSB of the word that just ended; next rise starts a new word.
        shift_d = '0;
        cnt_d   = '0;
        case (state_q)
          ST_SYNC: begin
            if (is_right_to_left(lr_prev_q, lr_now_s)) begin
              state_d = ST_LEFT;
            end else begin
              state_d = ST_SYNC;
            end
          end
          ST_LEFT: begin
            len_err_d = len_bad_s;
            if (lr_now_s == LR_RIGHT) begin
              left_d  = word_s;
              state_d = ST_RIGHT;
            end else begin
              state_d = ST_LEFT;
            end
          end
          ST_RIGHT: begin
            len_err_d = len_bad_s;
            if (lr_now_s == LR_LEFT) begin
              sample_d  = {left_q, word_s};
              valid_d   = 1'b1;
              overrun_d = valid_q & ~out_if.ready;
              state_d   = ST_LEFT;
            end else begin
              state_d = ST_RIGHT;
            end
          end
          default: begin
            state_d = ST_SYNC;
          end
        endcase
      end else begin
        shift_d = word_s;
        cnt_d   = cnt_inc_s;
      end
    end else begin
      lr_prev_d = lr_prev_q;
    end
  end

  // Receiver registers.
  always_ff @(posedge clkin or posedge rst_int) begin
    if (rst_int) begin
      state_q   <= ST_SYNC;
      lr_prev_q <= 1'b0;
      shift_q   <= '0;
      cnt_q     <= '0;
      left_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lr_prev_q <= lr_prev_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      len_err_q <= len_err_d;
    end
  end

  assign out_if.sample  = sample_q;
  assign out_if.valid   = valid_q;
  assign out_if.overrun = overrun_q;
  assign out_if.len_err = len_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: an I2S transmitter BFM, a bit-stream reference
// model of the framing rules, and a handshake monitor.
module tb_i2s_rx;

  localparam int DW = 16;

  logic clkin = 1'b0;
  logic rst;
  logic sck;
  logic lrck;
  logic sd;

  i2s_rx_if #(.DATA_WIDTH(DW)) rx_if ();

  i2s_rx #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clkin (clkin),
    .rst   (rst),
    .sck   (sck),
    .lrck  (lrck),
    .sd    (sd),
    .out_if(rx_if)
  );

  always #5 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: samples one time unit before each rising edge, where the handshake resolves.
  logic [31:0] obs_q[$];
  int len_err_cnt = 0;
  int overrun_cnt = 0;
  int vh_cnt      = 0;

  always begin
    @(negedge clkin);
    #4;
    if (rx_if.valid) vh_cnt++;
    if (rx_if.valid && rx_if.ready) obs_q.push_back(rx_if.sample);
    if (rx_if.len_err) len_err_cnt++;
    if (rx_if.overrun) overrun_cnt++;
  end

  // Reference model: consumes the bit stream exactly as transmitted.
  int          m_state;   // 0 = hunting for right->left, 1 = collecting left, 2 = collecting right
  bit          m_prev;
  bit          m_bits[$];
  logic [15:0] m_left;
  logic [31:0] exp_q[$];
  int          exp_len = 0;

  function automatic void model_reset();
    m_state = 0;
    m_prev  = 1'b0;
    m_bits.delete();
  endfunction

  function automatic logic [15:0] kept_word();
    logic [15:0] w = '0;
    for (int i = 0; i < DW; i++) begin
      if (i < m_bits.size()) w[DW-1-i] = m_bits[i];
    end
    return w;
  endfunction

  function automatic void model_bit(input bit lr, input bit b);
    logic [15:0] w;
    bit          bad;
    m_bits.push_back(b);
    if (lr != m_prev) begin
      w   = kept_word();
      bad = (m_bits.size() != DW);
      if (m_state == 0) begin
        if (m_prev == 1'b1 && lr == 1'b0) m_state = 1;
      end else if (m_state == 1) begin
        if (bad) exp_len++;
        m_left  = w;
        m_state = 2;
      end else begin
        if (bad) exp_len++;
        exp_q.push_back({m_left, w});
        m_state = 1;
      end
      m_bits.delete();
    end
    m_prev = lr;
  endfunction

  // Stimulus BFM.
  int          rdy_mode;   // 0 = low, 1 = high, 2 = random per cycle
  logic [31:0] hook_exp;

  task automatic tick();
    @(negedge clkin);
    if (rdy_mode == 0) rx_if.ready = 1'b0;
    else if (rdy_mode == 1) rx_if.ready = 1'b1;
    else rx_if.ready = 1'($urandom_range(0, 1));
  endtask

  // One SCK period of 8 clkin cycles; data and LRCK change while SCK is low.
  // hook 1: check frame latency, hook 2: raise ready in the frame-load cycle.
  task automatic send_bit(input bit lr, input bit b, input int hook);
    sck  = 1'b0;
    lrck = lr;
    sd   = b;
    repeat (4) tick();
    sck = 1'b1;
    model_bit(lr, b);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (hook == 1 && i == 2) check("lat_before", 64'(rx_if.valid), 64'd0);
      if (hook == 1 && i == 3) begin
        check("lat_valid", 64'(rx_if.valid), 64'd1);
        check("lat_sample", 64'(rx_if.sample), 64'(hook_exp));
      end
      if (hook == 1 && i == 4) check("one_cycle_valid", 64'(rx_if.valid), 64'd0);
      if (hook == 2 && i == 2) begin
        check("simul_old_valid", 64'(rx_if.valid), 64'd1);
        rx_if.ready = 1'b1;
      end
      if (hook == 2 && i == 3) begin
        rx_if.ready = 1'b0;
        check("simul_valid", 64'(rx_if.valid), 64'd1);
        check("simul_sample", 64'(rx_if.sample), 64'(hook_exp));
      end
    end
  endtask

  typedef struct {
    bit          ch;
    logic [31:0] val;
    int          len;
  } word_t;
  word_t wq[$];

  task automatic add_word(input bit ch, input logic [31:0] val, input int len);
    word_t w;
    w.ch = ch;
    w.val = val;
    w.len = len;
    wq.push_back(w);
  endtask

  // Send queued words; each LSB goes out with the following word's LRCK level.
  task automatic flush(input bit next_ch, input int hook);
    for (int k = 0; k < wq.size(); k++) begin
      bit nch;
      nch = (k + 1 < wq.size()) ? wq[k+1].ch : next_ch;
      for (int j = wq[k].len - 1; j >= 0; j--) begin
        send_bit((j == 0) ? nch : wq[k].ch, wq[k].val[j],
                 (j == 0 && k == wq.size() - 1) ? hook : 0);
      end
    end
    wq.delete();
  endtask

  task automatic drain();
    rdy_mode = 1;
    repeat (4) tick();
  endtask

  function automatic logic [31:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 'x;
  endfunction

  task automatic compare_frames(input string tag, input int ob, input int eb);
    int n;
    check({tag, "_count"}, 64'(obs_q.size() - ob), 64'(exp_q.size() - eb));
    n = (obs_q.size() - ob < exp_q.size() - eb) ? obs_q.size() - ob : exp_q.size() - eb;
    for (int i = 0; i < n; i++) check({tag, "_frame"}, 64'(obs_q[ob+i]), 64'(exp_q[eb+i]));
  endtask

  int ob, eb, lb, el, orb, vb;
  logic [15:0] r1, r2;

  initial begin
    rst = 1'b1; sck = 1'b0; lrck = 1'b0; sd = 1'b0;
    rx_if.ready = 1'b0; rdy_mode = 0; hook_exp = '0;
    model_reset();
    repeat (3) @(negedge clkin);
    check("rst_sample", 64'(rx_if.sample), 64'd0);
    check("rst_valid", 64'(rx_if.valid), 64'd0);
    check("rst_overrun", 64'(rx_if.overrun), 64'd0);
    check("rst_len_err", 64'(rx_if.len_err), 64'd0);
    rst = 1'b0;
    repeat (5) tick();

    // Lock: stream starts in the middle of a right word.
    ob = obs_q.size(); eb = exp_q.size(); lb = len_err_cnt; el = exp_len;
    rdy_mode = 1;
    add_word(1'b1, 32'h55, 7);
    add_word(1'b0, 32'h0001, 16);
    add_word(1'b1, 32'h8000, 16);
    flush(1'b0, 0);
    drain();
    compare_frames("lock", ob, eb);
    check("lock_first", 64'(obs_at(ob)), 64'h0001_8000);
    check("lock_len_err", 64'(len_err_cnt - lb), 64'd0);

    // Basic: lead-in frame then A5C3/1234 with latency check.
    ob = obs_q.size(); eb = exp_q.size(); vb = vh_cnt; orb = overrun_cnt;
    hook_exp = 32'hA5C3_1234;
    add_word(1'b0, 32'($urandom_range(0, 65535)), 16);
    add_word(1'b1, 32'($urandom_range(0, 65535)), 16);
    add_word(1'b0, 32'hA5C3, 16);
    add_word(1'b1, 32'h1234, 16);
    flush(1'b0, 1);
    drain();
    compare_frames("basic", ob, eb);
    check("basic_last", 64'(obs_at(obs_q.size() - 1)), 64'hA5C3_1234);
    check("basic_vcycles", 64'(vh_cnt - vb), 64'(obs_q.size() - ob));
    check("basic_overrun", 64'(overrun_cnt - orb), 64'd0);

    // Simultaneous: ready rises exactly in the cycle the second frame loads.
    ob = obs_q.size(); eb = exp_q.size(); orb = overrun_cnt;
    rdy_mode = 0;
    r1 = 16'($urandom_range(0, 65535));
    r2 = 16'($urandom_range(0, 65535));
    hook_exp = {r1, r2};
    add_word(1'b0, 32'($urandom_range(0, 65535)), 16);
    add_word(1'b1, 32'($urandom_range(0, 65535)), 16);
    add_word(1'b0, 32'(r1), 16);
    add_word(1'b1, 32'(r2), 16);
    flush(1'b0, 2);
    tick();
    check("simul_overrun", 64'(overrun_cnt - orb), 64'd0);
    drain();
    compare_frames("simul", ob, eb);

    // Backpressure: two frames with nothing consumed.
    ob = obs_q.size(); orb = overrun_cnt;
    rdy_mode = 0;
    add_word(1'b0, 32'h1111, 16);
    add_word(1'b1, 32'h2222, 16);
    add_word(1'b0, 32'h3333, 16);
    add_word(1'b1, 32'h4444, 16);
    flush(1'b0, 0);
    tick();
    check("bp_overrun", 64'(overrun_cnt - orb), 64'd1);
    check("bp_valid", 64'(rx_if.valid), 64'd1);
    check("bp_sample", 64'(rx_if.sample), 64'h3333_4444);
    check("bp_model", 64'(rx_if.sample), 64'(exp_q[exp_q.size()-1]));
    rdy_mode = 1;
    tick();
    tick();
    check("bp_valid_drop", 64'(rx_if.valid), 64'd0);
    check("bp_consumed", 64'(obs_q.size() - ob), 64'd1);
    check("bp_consumed_val", 64'(obs_at(ob)), 64'h3333_4444);

    // Length: 12-bit left, 20-bit right.
    ob = obs_q.size(); eb = exp_q.size(); lb = len_err_cnt; el = exp_len;
    add_word(1'b0, 32'hABC, 12);
    add_word(1'b1, 32'hFFFF0, 20);
    flush(1'b0, 0);
    drain();
    compare_frames("len", ob, eb);
    check("len_frame", 64'(obs_at(ob)), 64'hABC0_FFFF);
    check("len_err_pulses", 64'(len_err_cnt - lb), 64'd2);
    check("len_err_model", 64'(len_err_cnt - lb), 64'(exp_len - el));

    // Random frames with random consumer.
    ob = obs_q.size(); eb = exp_q.size(); lb = len_err_cnt; orb = overrun_cnt;
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      add_word(1'b0, 32'($urandom_range(0, 65535)), 16);
      add_word(1'b1, 32'($urandom_range(0, 65535)), 16);
    end
    flush(1'b0, 0);
    drain();
    compare_frames("rand", ob, eb);
    check("rand_overrun", 64'(overrun_cnt - orb), 64'd0);
    check("rand_len_err", 64'(len_err_cnt - lb), 64'd0);

    // Reset in the middle of a left word with a frame still pending.
    rdy_mode = 0;
    add_word(1'b0, 32'($urandom_range(0, 65535)), 16);
    add_word(1'b1, 32'($urandom_range(0, 65535)), 16);
    flush(1'b0, 0);
    for (int j = 0; j < 5; j++) send_bit(1'b0, 1'($urandom_range(0, 1)), 0);
    tick();
    check("pre_rst_valid", 64'(rx_if.valid), 64'd1);
    sck = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sample", 64'(rx_if.sample), 64'd0);
    check("mid_rst_valid", 64'(rx_if.valid), 64'd0);
    check("mid_rst_overrun", 64'(rx_if.overrun), 64'd0);
    check("mid_rst_len_err", 64'(rx_if.len_err), 64'd0);
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    repeat (6) tick();
    check("post_rst_valid", 64'(rx_if.valid), 64'd0);
    ob = obs_q.size(); eb = exp_q.size(); lb = len_err_cnt;
    rdy_mode = 1;
    add_word(1'b0, 32'($urandom_range(0, 2047)), 11);
    add_word(1'b1, 32'($urandom_range(0, 65535)), 16);
    add_word(1'b0, 32'hBEEF, 16);
    add_word(1'b1, 32'hCAFE, 16);
    flush(1'b0, 0);
    drain();
    compare_frames("post_rst", ob, eb);
    check("post_rst_count", 64'(obs_q.size() - ob), 64'd1);
    check("post_rst_frame", 64'(obs_at(ob)), 64'hBEEF_CAFE);
    check("post_rst_len_err", 64'(len_err_cnt - lb), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S slave receiver: captures externally driven SCK/LRCK/SD into the clkin domain.
- Deserialises MSB-first left/right words (standard I2S, 1-bit delay after LRCK edge).
- Presents each stereo frame as one {left,right} word on a valid/ready interface.
- Sits at the ADC/codec input of the audio path, mirroring the output-side I2S transmitter.

Parameters:
- DATA_WIDTH, 16, bits per channel word kept; output is 2*DATA_WIDTH wide.
- CNT_WIDTH, 6, width of per-channel bit counter (saturates at 2^CNT_WIDTH-1).

Ports:
- clkin  input  1  system clock; must be >= 4x SCK frequency.
- rst  input  1  asynchronous, active-high reset.
- sck  input  1  I2S bit clock from pin, asynchronous to clkin.
- lrck  input  1  I2S word select from pin; 0 = left, 1 = right.
- sd  input  1  I2S serial data from pin.
- sample  output  2*DATA_WIDTH  {left, right}; left in MSBs.
- valid  output  1  sample holds an unconsumed frame.
- ready  input  1  consumer accepts sample when valid && ready.
- overrun  output  1  one-cycle pulse: a frame overwrote an unconsumed one.
- len_err  output  1  one-cycle pulse: a channel word length != DATA_WIDTH.

Behaviour:
- Reset (async assert, sync deassert inside design): sample=0, valid=0, overrun=0, len_err=0, all sync flops 0, state=SYNC.
- Synchronisation: sck, lrck, sd each pass through 2 flops; a third sck flop gives rise = s2 & ~s3. All work happens only in rise cycles; SCK falling edges are ignored.
- On each rise: sampled lrck (lr_now) is compared with lr_prev (lrck at previous rise).
  - Equal: the SD bit is a data bit of the current word.
  - Differ (boundary): the SD bit is the LSB of the word just ending; the next rise carries the MSB of the new word.
- Word assembly: shift register, MSB first.
  - First DATA_WIDTH bits of a word are kept.
  - Extra bits are discarded.
  - A short word is left-aligned and zero-padded in the LSBs.
  - Bit counter counts all bits of the word, saturating.
  - At each boundary, counter != DATA_WIDTH -> len_err pulse (only in LEFT/RIGHT states).
- State machine:
  - SYNC: discard bits. Boundary with lr 1->0 -> LEFT. Boundary 0->1 stays SYNC (never emits a partial frame).
  - LEFT: boundary 0->1 -> latch left word, go RIGHT.
  - RIGHT: boundary 1->0 -> frame complete, go LEFT.
- Frame complete:
  - sample <= {left, right_word}; valid <= 1.
  - Latency: 1 clkin cycle after the rise cycle that detects the boundary.
- Handshake:
  - valid stays high until a cycle with valid && ready; valid then drops the next cycle unless a new frame loads in that same cycle.
  - Frame complete with valid=1 and ready=0: overwrite sample, pulse overrun, valid stays 1.
  - Frame complete with valid && ready in the same cycle: load new sample, valid stays 1, no overrun.
- lrck change without an SCK rise has no effect; the comparison is only ever made at rises.
- Reset mid-frame: all state lost; next frame emitted only after a fresh 1->0 boundary.

Decomposition:
- Package i2s_pkg holds:
  - rx state enum (SYNC, LEFT, RIGHT);
  - LR_LEFT=0 and LR_RIGHT=1 constants;
  - default DATA_WIDTH=16, shared with the transmitter.
- Sub-module i2s_sync_edge: 2-flop synchroniser plus edge detect.
  - Instantiated for sck (uses rise); lrck and sd use its synchronised output only.
  - Keeps all pin-crossing logic in one place.

Test Plan:
- Basic: BFM drives SCK=clkin/8, 32 SCK per frame, left=0xA5C3, right=0x1234 after one lead-in frame -> sample=0xA5C31234, valid high 1 cycle after final boundary rise; ready held 1 -> valid one cycle only.
- Lock: start stimulus mid-right word, then frames L=0x0001 R=0x8000 -> first partial frame dropped, first output 0x00018000, len_err never pulses.
- Backpressure: ready=0 across two frames 0x11112222 then 0x33334444 -> overrun pulses once, sample=0x33334444, valid stays 1; raise ready -> valid drops next cycle.
- Length: 12-bit left word 0xABC, 20-bit right word 0xFFFF0 -> left 0xABC0, right 0xFFFF, len_err pulses at each of the two boundaries.
- Simultaneous: ready asserted exactly in the frame-complete cycle with valid=1 -> new sample loaded, valid continuous, no overrun.
- Reset: assert rst mid-left word -> all outputs 0 immediately; after release, first output only after the next full frame.
